// File: rtl/instr_sequencer.sv
// Multi-cycle control unit for the 8-register bus processor: latches an instruction
// and sequences register-field selects and bus controls through states T0..T3.
module instr_sequencer #(
    parameter int REG_BITS = 3,
    parameter int OP_BITS  = 3
) (
    input  logic                           clock,
    input  logic                           resetn,
    input  logic                           run,
    input  logic [OP_BITS+2*REG_BITS-1:0]  instr,
    output logic                           ir_in,
    output logic [REG_BITS-1:0]            rd_sel,
    output logic                           rd_en,
    output logic [REG_BITS-1:0]            wr_sel,
    output logic                           wr_en,
    output logic                           din_out,
    output logic                           a_in,
    output logic                           g_in,
    output logic                           g_out,
    output logic                           addsub,
    output logic                           done
);

    localparam int IW = OP_BITS + 2 * REG_BITS;

    localparam logic [OP_BITS-1:0] OP_MV  = OP_BITS'(0);
    localparam logic [OP_BITS-1:0] OP_MVI = OP_BITS'(1);
    localparam logic [OP_BITS-1:0] OP_ADD = OP_BITS'(2);
    localparam logic [OP_BITS-1:0] OP_SUB = OP_BITS'(3);

    typedef enum logic [1:0] {T0, T1, T2, T3} state_t;

    state_t              state, next_state;
    logic [IW-1:0]       ir;
    logic [OP_BITS-1:0]  op;
    logic [REG_BITS-1:0] rx, ry;

    assign op = ir[IW-1 -: OP_BITS];
    assign rx = ir[2*REG_BITS-1 -: REG_BITS];
    assign ry = ir[REG_BITS-1:0];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= T0;
            ir    <= '0;
        end else begin
            state <= next_state;
            if (state == T0 && run)
                ir <= instr;
        end
    end

    // NOTE: every output and next_state gets a default first, so no path
    // through the case statements can infer a latch.
    always_comb begin
        next_state = state;
        ir_in      = 1'b0;
        rd_sel     = '0;
        rd_en      = 1'b0;
        wr_sel     = '0;
        wr_en      = 1'b0;
        din_out    = 1'b0;
        a_in       = 1'b0;
        g_in       = 1'b0;
        g_out      = 1'b0;
        addsub     = 1'b0;
        done       = 1'b0;

        // While reset is held the outputs mirror the idle T0 state with run ignored.
        if (resetn) begin
            case (state)
                T0: begin
                    ir_in = run;
                    if (run)
                        next_state = T1;
                end
                T1: begin
                    case (op)
                        OP_MV: begin
                            rd_en      = 1'b1;
                            rd_sel     = ry;
                            wr_en      = 1'b1;
                            wr_sel     = rx;
                            done       = 1'b1;
                            next_state = T0;
                        end
                        OP_MVI: begin
                            din_out    = 1'b1;
                            wr_en      = 1'b1;
                            wr_sel     = rx;
                            done       = 1'b1;
                            next_state = T0;
                        end
                        OP_ADD, OP_SUB: begin
                            rd_en      = 1'b1;
                            rd_sel     = rx;
                            a_in       = 1'b1;
                            next_state = T2;
                        end
                        default: begin
                            // Reserved opcodes complete as a NOP.
                            done       = 1'b1;
                            next_state = T0;
                        end
                    endcase
                end
                T2: begin
                    rd_en      = 1'b1;
                    rd_sel     = ry;
                    g_in       = 1'b1;
                    addsub     = op[0];
                    next_state = T3;
                end
                T3: begin
                    g_out      = 1'b1;
                    wr_en      = 1'b1;
                    wr_sel     = rx;
                    done       = 1'b1;
                    next_state = T0;
                end
            endcase
        end
    end

endmodule
